// File: rtl/hdlc_tx_framer.sv
// hdlc_tx_framer
// HDLC transmit framer. Takes payload bytes from a valid/ready stream and
// serialises them LSB first as: start flag 0x7E, zero-stuffed payload,
// optional FCS, end flag 0x7E. The line idles high, and an abort pattern
// (0 followed by seven 1s) replaces the rest of a frame that is aborted or
// runs out of data.
// Optional feature macro: TX_FCS_EN -- when defined, a CRC-16-CCITT FCS
// (reflected, init 0xFFFF, sent ones-complemented) follows the payload.
module hdlc_tx_framer #(
  parameter int MAX_BYTES = 128
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_Start,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_DataValid,
  input  logic       Tx_DataLast,
  output logic       Tx_DataReady,
  input  logic       Tx_AbortFrame,
  output logic       Tx,
  output logic       Tx_ValidFrame,
  output logic       Tx_AbortedTrans,
  output logic       Tx_Done
);

  localparam logic [7:0] FLAG_PAT  = 8'h7E;
  localparam logic [7:0] ABORT_PAT = 8'hFE;
  localparam logic [7:0] MAX_CNT   = 8'(MAX_BYTES);
  localparam logic [7:0] MAX_M1    = 8'(MAX_BYTES - 1);

`ifdef TX_FCS_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START_FLAG,
    S_DATA,
    S_FCS,
    S_END_FLAG,
    S_ABORT
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_START_FLAG,
    S_DATA,
    S_END_FLAG,
    S_ABORT
  } state_t;
`endif

  // Every register describes the bit currently on the line: r_bitIdx is its
  // position in the current unit (flag, byte or FCS word), r_stuff marks an
  // inserted zero, r_ones counts the consecutive 1s sent so far including it.
  state_t      r_state;
  logic [3:0]  r_bitIdx;
  logic [15:0] r_shift;
  logic [2:0]  r_ones;
  logic        r_stuff;
  logic        r_last;
  logic [7:0]  r_byteCnt;
  logic        r_tx;
  logic        r_validFrame;
  logic        r_done;
  logic        r_aborted;
`ifdef TX_FCS_EN
  logic [15:0] r_crc;

  // Reflected CRC-16-CCITT update over one byte, LSB first.
  function automatic logic [15:0] crcByte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction
`endif

  logic [3:0] w_endIdx;
  logic [3:0] w_nextIdx;
  logic       w_nextBit;
  logic       w_needStuff;
  logic       w_unitEnd;
  logic       w_loadSlot;
  logic       w_canAbort;
  logic       w_underrun;
  logic       w_loadLast;
  logic [2:0] w_loadOnes;

  // Decode where the current bit sits in its unit and whether the next
  // payload byte is due. The ready handshake is decoded combinationally so
  // that an abort arriving in the same cycle can still cancel the load.
  always_comb begin
    w_endIdx    = 4'd7;
`ifdef TX_FCS_EN
    if (r_state == S_FCS) begin
      w_endIdx = 4'd15;
    end
`endif
    w_nextIdx   = r_bitIdx + 4'd1;
    w_nextBit   = r_shift[w_nextIdx];
    w_needStuff = (r_ones == 3'd5);
    w_unitEnd   = !w_needStuff && (r_bitIdx == w_endIdx);
    w_loadSlot  = ((r_state == S_START_FLAG) && (r_bitIdx == 4'd7)) ||
                  ((r_state == S_DATA) && w_unitEnd && !r_last);
    w_canAbort  = (r_state == S_START_FLAG) || (r_state == S_DATA);
`ifdef TX_FCS_EN
    if (r_state == S_FCS) begin
      w_canAbort = 1'b1;
    end
`endif
    w_underrun   = w_loadSlot && !Tx_DataValid;
    Tx_DataReady = w_loadSlot && Tx_DataValid && !Tx_AbortFrame;
    w_loadLast   = Tx_DataLast || (r_byteCnt >= MAX_M1);
    w_loadOnes   = Tx_Data[0] ? (r_ones + 3'd1) : 3'd0;
  end

  // Framing state machine: chooses the next line bit and registers it
  // together with the frame status outputs.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state      <= S_IDLE;
      r_bitIdx     <= 4'd0;
      r_shift      <= 16'h0000;
      r_ones       <= 3'd0;
      r_stuff      <= 1'b0;
      r_last       <= 1'b0;
      r_byteCnt    <= 8'd0;
      r_tx         <= 1'b1;
      r_validFrame <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
`ifdef TX_FCS_EN
      r_crc        <= 16'hFFFF;
`endif
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      if (w_canAbort && (Tx_AbortFrame || w_underrun)) begin
        r_state      <= S_ABORT;
        r_bitIdx     <= 4'd0;
        r_stuff      <= 1'b0;
        r_ones       <= 3'd0;
        r_tx         <= ABORT_PAT[0];
        r_validFrame <= 1'b0;
      end else if (Tx_DataReady) begin
        r_state  <= S_DATA;
        r_shift  <= {8'h00, Tx_Data};
        r_bitIdx <= 4'd0;
        r_stuff  <= 1'b0;
        r_tx     <= Tx_Data[0];
        r_ones   <= w_loadOnes;
        r_last   <= w_loadLast;
        if (r_byteCnt < MAX_CNT) begin
          r_byteCnt <= r_byteCnt + 8'd1;
        end
`ifdef TX_FCS_EN
        r_crc <= crcByte(r_crc, Tx_Data);
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            r_tx      <= 1'b1;
            r_byteCnt <= 8'd0;
            r_ones    <= 3'd0;
            r_stuff   <= 1'b0;
            r_bitIdx  <= 4'd0;
            r_last    <= 1'b0;
`ifdef TX_FCS_EN
            r_crc     <= 16'hFFFF;
`endif
            if (Tx_Start && Tx_DataValid) begin
              r_state      <= S_START_FLAG;
              r_tx         <= FLAG_PAT[0];
              r_validFrame <= 1'b1;
            end
          end
          S_START_FLAG: begin
            r_bitIdx <= w_nextIdx;
            r_tx     <= FLAG_PAT[w_nextIdx[2:0]];
          end
`ifdef TX_FCS_EN
          S_DATA, S_FCS: begin
`else
          S_DATA: begin
`endif
            if (w_needStuff) begin
              r_stuff <= 1'b1;
              r_tx    <= 1'b0;
              r_ones  <= 3'd0;
            end else if (!w_unitEnd) begin
              r_stuff  <= 1'b0;
              r_bitIdx <= w_nextIdx;
              r_tx     <= w_nextBit;
              r_ones   <= w_nextBit ? (r_ones + 3'd1) : 3'd0;
`ifdef TX_FCS_EN
            end else if (r_state == S_DATA) begin
              r_state  <= S_FCS;
              r_shift  <= ~r_crc;
              r_bitIdx <= 4'd0;
              r_stuff  <= 1'b0;
              r_tx     <= ~r_crc[0];
              r_ones   <= (~r_crc[0]) ? (r_ones + 3'd1) : 3'd0;
`endif
            end else begin
              r_state  <= S_END_FLAG;
              r_bitIdx <= 4'd0;
              r_stuff  <= 1'b0;
              r_ones   <= 3'd0;
              r_tx     <= FLAG_PAT[0];
            end
          end
          S_END_FLAG: begin
            if (r_bitIdx != 4'd7) begin
              r_bitIdx <= w_nextIdx;
              r_tx     <= FLAG_PAT[w_nextIdx[2:0]];
            end else begin
              r_state      <= S_IDLE;
              r_bitIdx     <= 4'd0;
              r_tx         <= 1'b1;
              r_validFrame <= 1'b0;
              r_done       <= 1'b1;
            end
          end
          S_ABORT: begin
            if (r_bitIdx != 4'd7) begin
              r_bitIdx <= w_nextIdx;
              r_tx     <= ABORT_PAT[w_nextIdx[2:0]];
            end else begin
              r_state   <= S_IDLE;
              r_bitIdx  <= 4'd0;
              r_tx      <= 1'b1;
              r_aborted <= 1'b1;
            end
          end
          default: begin
            r_state      <= S_IDLE;
            r_tx         <= 1'b1;
            r_validFrame <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Tx              = r_tx;
  assign Tx_ValidFrame   = r_validFrame;
  assign Tx_AbortedTrans = r_aborted;
  assign Tx_Done         = r_done;

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// tb_hdlc_tx_framer
// Directed bench for hdlc_tx_framer. Expected line streams are written as
// vectors where bit i is the i-th transmitted bit, so a byte sent LSB first
// appears with its own value. A small MAX_BYTES keeps the length limit cheap
// to exercise. With TX_FCS_EN defined the complete-frame cases are replaced
// by a single-byte frame carrying its FCS.
module tb_hdlc_tx_framer;

  localparam int TB_MAX = 2;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Tx_Start;
  logic [7:0] Tx_Data;
  logic       Tx_DataValid;
  logic       Tx_DataLast;
  logic       Tx_DataReady;
  logic       Tx_AbortFrame;
  logic       Tx;
  logic       Tx_ValidFrame;
  logic       Tx_AbortedTrans;
  logic       Tx_Done;

  int checks = 0;
  int errors = 0;

  logic [7:0]  srcQ[$];
  logic        srcLastFlag;
  logic        pendPop;
  logic [63:0] capBits;
  int          validCnt, readyCnt, doneCnt, abortCnt, doneIdx, abortIdx;

  always #5 Clk = ~Clk;

  hdlc_tx_framer #(.MAX_BYTES(TB_MAX)) dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .Tx_Start        (Tx_Start),
    .Tx_Data         (Tx_Data),
    .Tx_DataValid    (Tx_DataValid),
    .Tx_DataLast     (Tx_DataLast),
    .Tx_DataReady    (Tx_DataReady),
    .Tx_AbortFrame   (Tx_AbortFrame),
    .Tx              (Tx),
    .Tx_ValidFrame   (Tx_ValidFrame),
    .Tx_AbortedTrans (Tx_AbortedTrans),
    .Tx_Done         (Tx_Done)
  );

  function automatic logic [63:0] lowMask(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

  // Present the head of the byte queue as the stream source.
  task automatic driveSource();
    Tx_DataValid = (srcQ.size() > 0);
    Tx_Data      = (srcQ.size() > 0) ? srcQ[0] : 8'h00;
    Tx_DataLast  = srcLastFlag && (srcQ.size() == 1);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Load a frame's bytes and raise Tx_Start for one cycle.
  task automatic applyStimulus(input logic lastFlag);
    @(negedge Clk);
    srcLastFlag = lastFlag;
    pendPop     = 1'b0;
    driveSource();
    Tx_Start    = 1'b1;
  endtask

  // Run a fixed number of cycles, recording the line and the status pulses.
  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic runFrame(input int nCycles, input int abortAt);
    capBits  = '0;
    validCnt = 0; readyCnt = 0; doneCnt = 0; abortCnt = 0;
    doneIdx  = -1; abortIdx = -1;
    for (int k = 0; k < nCycles; k++) begin
      @(negedge Clk);
      Tx_Start      = 1'b0;
      Tx_AbortFrame = (k == abortAt);
      if (pendPop && srcQ.size() > 0) void'(srcQ.pop_front());
      driveSource();
      #1;
      capBits[k] = Tx;
      if (Tx_ValidFrame) validCnt++;
      if (Tx_DataReady) readyCnt++;
      if (Tx_Done) begin doneCnt++; if (doneIdx < 0) doneIdx = k; end
      if (Tx_AbortedTrans) begin abortCnt++; if (abortIdx < 0) abortIdx = k; end
      pendPop = Tx_DataReady;
    end
    Tx_AbortFrame = 1'b0;
  endtask

  initial begin
    int run;
    int maxRun;
    Rst = 1'b0; Tx_Start = 1'b0; Tx_Data = 8'h00; Tx_DataValid = 1'b0;
    Tx_DataLast = 1'b0; Tx_AbortFrame = 1'b0; srcLastFlag = 1'b0; pendPop = 1'b0;
    $display("[TB] start");

    repeat (2) @(negedge Clk);
    #1;
    checkOutput("rst_tx",      64'(Tx), 64'd1);
    checkOutput("rst_valid",   64'(Tx_ValidFrame), 64'd0);
    checkOutput("rst_ready",   64'(Tx_DataReady), 64'd0);
    checkOutput("rst_done",    64'(Tx_Done), 64'd0);
    checkOutput("rst_aborted", 64'(Tx_AbortedTrans), 64'd0);
    @(negedge Clk);
    Rst = 1'b1;

    // Start without data and an abort in idle are both ignored.
    applyStimulus(1'b1);
    runFrame(4, 1);
    checkOutput("nodata_tx",    capBits & lowMask(4), 64'hF);
    checkOutput("nodata_valid", 64'(validCnt), 64'd0);
    checkOutput("nodata_abort", 64'(abortCnt), 64'd0);

`ifndef TX_FCS_EN
    // Single zero byte.
    srcQ = '{8'h00};
    applyStimulus(1'b1);
    runFrame(26, -1);
    checkOutput("t1_bits",     capBits & lowMask(26), 64'({2'b11, 24'h7E007E}));
    checkOutput("t1_valid",    64'(validCnt), 64'd24);
    checkOutput("t1_done_cnt", 64'(doneCnt), 64'd1);
    checkOutput("t1_done_idx", 64'(doneIdx), 64'd24);
    checkOutput("t1_ready",    64'(readyCnt), 64'd1);

    // All-ones byte forces one stuffed zero.
    srcQ = '{8'hFF};
    applyStimulus(1'b1);
    runFrame(27, -1);
    checkOutput("t2_bits",     capBits & lowMask(27), 64'({2'b11, 25'h0FDDF7E}));
    checkOutput("t2_valid",    64'(validCnt), 64'd25);
    checkOutput("t2_done_idx", 64'(doneIdx), 64'd25);

    // Two flag-valued bytes: each gets a stuffed zero.
    srcQ = '{8'h7E, 8'h7E};
    applyStimulus(1'b1);
    runFrame(36, -1);
    checkOutput("t3_bits",     capBits & lowMask(36), 64'({2'b11, 34'h1F97CBE7E}));
    checkOutput("t3_ready",    64'(readyCnt), 64'd2);
    checkOutput("t3_done_idx", 64'(doneIdx), 64'd34);
    run = 0; maxRun = 0;
    for (int i = 8; i < 26; i++) begin
      run = capBits[i] ? run + 1 : 0;
      if (run > maxRun) maxRun = run;
    end
    checkOutput("t3_max_ones_run", 64'(maxRun), 64'd5);

    // No last marker: the length limit closes the frame after TB_MAX bytes.
    srcQ = '{8'h00, 8'h00, 8'h00};
    applyStimulus(1'b0);
    runFrame(34, -1);
    checkOutput("max_bits",     capBits & lowMask(34), 64'({2'b11, 32'h7E00007E}));
    checkOutput("max_ready",    64'(readyCnt), 64'd2);
    checkOutput("max_done_idx", 64'(doneIdx), 64'd32);
    srcQ.delete();
`else
    // Single byte 0x01 followed by FCS 0xE1F1 (stuffed once).
    srcQ = '{8'h01};
    applyStimulus(1'b1);
    runFrame(43, -1);
    checkOutput("t6_bits",     capBits & lowMask(43), 64'({2'b11, 41'h0FDC1F1017E}));
    checkOutput("t6_valid",    64'(validCnt), 64'd41);
    checkOutput("t6_done_idx", 64'(doneIdx), 64'd41);
`endif

    // Abort while the second byte is on the line.
    srcQ = '{8'h00, 8'h00};
    applyStimulus(1'b1);
    runFrame(30, 19);
    checkOutput("t4_bits",      capBits & lowMask(30), 64'({2'b11, 28'hFE0007E}));
    checkOutput("t4_valid",     64'(validCnt), 64'd20);
    checkOutput("t4_abort_idx", 64'(abortIdx), 64'd28);
    checkOutput("t4_done",      64'(doneCnt), 64'd0);
    checkOutput("t4_ready",     64'(readyCnt), 64'd2);
    srcQ.delete();

    // Underrun: the only byte is not marked last.
    srcQ = '{8'h00};
    applyStimulus(1'b0);
    runFrame(26, -1);
    checkOutput("t5_bits",      capBits & lowMask(26), 64'({2'b11, 24'hFE007E}));
    checkOutput("t5_valid",     64'(validCnt), 64'd16);
    checkOutput("t5_ready",     64'(readyCnt), 64'd1);
    checkOutput("t5_abort_idx", 64'(abortIdx), 64'd24);
    checkOutput("t5_done",      64'(doneCnt), 64'd0);

    // Reset in the middle of the start flag returns the line to idle at once.
    srcQ = '{8'h00};
    applyStimulus(1'b1);
    runFrame(4, -1);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    checkOutput("midrst_tx",    64'(Tx), 64'd1);
    checkOutput("midrst_valid", 64'(Tx_ValidFrame), 64'd0);
    @(negedge Clk);
    Rst = 1'b1;
    srcQ.delete();
    runFrame(4, -1);
    checkOutput("midrst_idle", capBits & lowMask(4), 64'hF);
    checkOutput("midrst_abort", 64'(abortCnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
